// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: opcodes, widths, FSM state type and single-cycle ALU helpers for tinyalu_core.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package tinyalu_pkg;

    localparam int OPERAND_W = 8;
    localparam int RESULT_W  = 16;

    // Opcode encoding on the op bus; 101 and 110 are unassigned and treated as illegal.
    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    localparam logic [2:0] OP_NOP = 3'(no_op);
    localparam logic [2:0] OP_ADD = 3'(add_op);
    localparam logic [2:0] OP_AND = 3'(and_op);
    localparam logic [2:0] OP_XOR = 3'(xor_op);
    localparam logic [2:0] OP_MUL = 3'(mul_op);
    localparam logic [2:0] OP_RST = 3'(rst_op);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    typedef logic [OPERAND_W-1:0] operand_t;
    typedef logic [RESULT_W-1:0]  result_t;

    // True for opcodes that complete with a real result in a single cycle.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);
    endfunction

    // Single-cycle datapath; add keeps its carry in bit 8.
    function automatic result_t alu_single(input logic [2:0] op, input operand_t a, input operand_t b);
        result_t r;
        r = '0;
        case (op)
            OP_ADD:  r = {7'b0, {1'b0, a} + {1'b0, b}};
            OP_AND:  r = {8'b0, a & b};
            OP_XOR:  r = {8'b0, a ^ b};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// tinyalu_mul_pipe: registers the full 16-bit A*B product when in_vld is high and tracks it with a valid chain.
// Latency: product visible the cycle after in_vld; out_vld high in the cycle after edge (in_vld + MUL_LATENCY-1).
// Backpressure: none; caller issues one operation at a time and keeps the product until it has consumed it.
module tinyalu_mul_pipe import tinyalu_pkg::*; #(
    parameter int MUL_LATENCY = 3
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     in_vld,
    input  operand_t a_dat,
    input  operand_t b_dat,
    output result_t  prod_dat,
    output logic     out_vld
);

    // The accept edge itself is the first of the MUL_LATENCY edges, so the chain holds the remaining ones.
    logic [MUL_LATENCY-2:0] vld_sr;

    // Capture the product once at the accept edge; it is held until the next multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_dat <= '0;
        end else if (in_vld) begin
            prod_dat <= RESULT_W'(a_dat) * RESULT_W'(b_dat);
        end
    end

    // Shift the valid token along so it lines up with the completion edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= in_vld;
            for (int i = 1; i < MUL_LATENCY - 1; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    assign out_vld = vld_sr[MUL_LATENCY-2];

endmodule

// File: rtl/tinyalu_core.sv
// tinyalu_core: start/done ALU responder (add/and/xor/mul); multiplier present only when TINYALU_MUL_EN is defined.
// Latency: 1 cycle for single-cycle and illegal ops, MUL_LATENCY cycles for multiply; done/illegal pulse one cycle.
// Backpressure: start is held until done; a held start parks the FSM in WAIT_LOW so it cannot re-trigger.
module tinyalu_core import tinyalu_pkg::*; #(
    parameter int MUL_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [OPERAND_W-1:0] A,
    input  logic [OPERAND_W-1:0] B,
    output logic                 done,
    output logic [RESULT_W-1:0]  result,
    output logic                 illegal
);

    localparam bit LAT_OK = (MUL_LATENCY >= 2) && (MUL_LATENCY <= 8);

    state_t  state_q;
    state_t  state_d;
    logic    done_d;
    logic    illegal_d;
    result_t result_d;

    logic    accept;
    logic    mul_go;
    logic    mul_last;
    result_t mul_res;

    assign accept = (state_q == IDLE) && start;

`ifdef TINYALU_MUL_EN
    localparam int CNT_W = $clog2(MUL_LATENCY);

    logic [CNT_W-1:0] cnt_q;
    result_t          mul_prod;
    logic             mul_vld;

    assign mul_go   = accept && (op == OP_MUL);
    assign mul_last = (state_q == EXEC) && (cnt_q == CNT_W'(1));
    assign mul_res  = mul_prod;

    tinyalu_mul_pipe #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (mul_go),
        .a_dat    (A),
        .b_dat    (B),
        .prod_dat (mul_prod),
        .out_vld  (mul_vld)
    );

    // Latency counter: loads at accept and counts down to the completion edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (mul_go) begin
            cnt_q <= CNT_W'(MUL_LATENCY - 1);
        end else if ((state_q == EXEC) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // The pipe's valid token and the counter must agree on the completion cycle.
    mul_timing_agree: assert property (@(posedge clk) disable iff (reset) mul_vld == mul_last);
`else
    // No multiplier: opcode 100 falls through to the illegal path.
    assign mul_go   = 1'b0;
    assign mul_last = 1'b0;
    assign mul_res  = '0;
`endif

    // Multiply latency outside 2..8 is not a supported configuration.
    mul_latency_legal: assert property (@(posedge clk) LAT_OK);

    // State register; reset wins over a simultaneous accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every accepted command except multiply goes straight to WAIT_LOW.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = mul_go ? EXEC : WAIT_LOW;
                end
            end
            EXEC: begin
                if (mul_last) begin
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next-values: result only moves on the edge that raises done.
    always_comb begin
        done_d    = 1'b0;
        illegal_d = 1'b0;
        result_d  = result;
        if (accept) begin
            if (is_alu_op(op)) begin
                done_d   = 1'b1;
                result_d = alu_single(op, A, B);
            end else if ((op == OP_NOP) || mul_go) begin
                done_d = 1'b0;
            end else begin
                done_d    = 1'b1;
                illegal_d = 1'b1;
                result_d  = '0;
            end
        end else if (mul_last) begin
            done_d   = 1'b1;
            result_d = mul_res;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            done    <= 1'b0;
            illegal <= 1'b0;
            result  <= '0;
        end else begin
            done    <= done_d;
            illegal <= illegal_d;
            result  <= result_d;
        end
    end

endmodule

// File: tb/tb_tinyalu_core.sv
// tb_tinyalu_core: directed vectors with hand-computed results for tinyalu_core (MUL_LATENCY=3).
// Latency: checks done arrives exactly 1 cycle (single-cycle/illegal) or 3 cycles (multiply) after accept.
// Backpressure: drives start held until done and checks a held start never re-triggers.
module tb_tinyalu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        done;
    logic [15:0] result;
    logic        illegal;

    int checks = 0;
    int errs   = 0;
    int bad;

    tinyalu_core #(
        .MUL_LATENCY (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .A       (A),
        .B       (B),
        .done    (done),
        .result  (result),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command from IDLE at a negedge, wait for done, optionally keep start high afterwards.
    task automatic run_cmd(input string tag, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                           input int lat, input logic [15:0] res, input logic ill, input int hold);
        int   k;
        int   extra;
        logic seen;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        k     = 0;
        seen  = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                A  = ~a;
                B  = a ^ b;
                op = 3'b010;
            end
        end
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_res"}, result, res);
        chk({tag, "_ill"}, illegal, ill);
        extra = 0;
        repeat (hold) begin
            @(negedge clk);
            if (done !== 1'b0) extra++;
        end
        start = 1'b0;
        @(negedge clk);
        if (done !== 1'b0) extra++;
        chk({tag, "_pulse"}, extra, 0);
        chk({tag, "_held"}, result, res);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for two edges with a pending add request.
        reset = 1'b1;
        start = 1'b1;
        op    = 3'b001;
        A     = 8'h11;
        B     = 8'h22;
        repeat (2) begin
            @(negedge clk);
            chk("rst_done", done, 1'b0);
            chk("rst_result", result, 16'h0000);
            chk("rst_illegal", illegal, 1'b0);
        end
        reset = 1'b0;
        start = 1'b0;
        bad   = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) bad++;
        end
        chk("post_rst_quiet", bad, 0);
        chk("post_rst_result", result, 16'h0000);

        run_cmd("add_ff_01", 3'b001, 8'hFF, 8'h01, 1, 16'h0100, 1'b0, 0);
        run_cmd("and_f0_3c", 3'b010, 8'hF0, 8'h3C, 1, 16'h0030, 1'b0, 0);

        // no_op: accepted silently, result must hold at 0x0030.
        start = 1'b1;
        op    = 3'b000;
        A     = 8'h12;
        B     = 8'h34;
        bad   = 0;
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b0 || illegal !== 1'b0 || result !== 16'h0030) bad++;
        end
        chk("nop_quiet", bad, 0);
        chk("nop_result", result, 16'h0030);
        start = 1'b0;
        @(negedge clk);

        run_cmd("add_2_3", 3'b001, 8'h02, 8'h03, 1, 16'h0005, 1'b0, 0);
        run_cmd("xor_hold", 3'b011, 8'hF0, 8'h3C, 1, 16'h00CC, 1'b0, 5);

        // Reset coinciding with an accept: reset wins.
        start = 1'b1;
        op    = 3'b001;
        A     = 8'h01;
        B     = 8'h01;
        reset = 1'b1;
        @(negedge clk);
        chk("rstwin_done", done, 1'b0);
        chk("rstwin_result", result, 16'h0000);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rstwin_after", done, 1'b0);

        run_cmd("op_110", 3'b110, 8'h12, 8'h34, 1, 16'h0000, 1'b1, 0);
        run_cmd("add_7f_7f", 3'b001, 8'h7F, 8'h7F, 1, 16'h00FE, 1'b0, 0);
        run_cmd("op_111", 3'b111, 8'h55, 8'hAA, 1, 16'h0000, 1'b1, 0);

`ifdef TINYALU_MUL_EN
        run_cmd("mul_ff_ff", 3'b100, 8'hFF, 8'hFF, 3, 16'hFE01, 1'b0, 0);
        run_cmd("mul_0c_0b", 3'b100, 8'h0C, 8'h0B, 3, 16'h0084, 1'b0, 0);

        // Multiply accepted, reset one cycle later: command dropped.
        start = 1'b1;
        op    = 3'b100;
        A     = 8'h03;
        B     = 8'h04;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("mulrst_result", result, 16'h0000);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b0) bad++;
            if (result !== 16'h0000) bad++;
        end
        chk("mulrst_quiet", bad, 0);
`else
        run_cmd("mul_off", 3'b100, 8'h03, 8'h04, 1, 16'h0000, 1'b1, 0);
        run_cmd("mul_off_ff", 3'b100, 8'hFF, 8'hFF, 1, 16'h0000, 1'b1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
